// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | multicycle_control_unit: MIPS multicycle sequencer                        |
// | IFETCH/DECODE/EXEC/MEM/WB/HALT with mem-wait timeout and retire counter.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32,
  parameter int CHECK_OVF   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iren,
  output logic             dren,
  output logic             dwen,
  output logic             PC_EN,
  output logic [1:0]       PC_src,
  output logic             Ext_src,
  output logic             LUI_src,
  output logic [1:0]       portb_src,
  output logic [1:0]       RegDst,
  output logic             RegWEN,
  output logic [1:0]       MemtoReg,
  output logic [3:0]       ALU_op,
  output logic             check_over,
  output logic             halt,
  output logic             mem_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
                         FN_SLTU = 6'h2B;
  localparam logic [3:0] ALU_SLL = 4'h0, ALU_SRL = 4'h1, ALU_ADD = 4'h2, ALU_SUB = 4'h3,
                         ALU_AND = 4'h4, ALU_OR = 4'h5, ALU_XOR = 4'h6, ALU_NOR = 4'h7,
                         ALU_SLT = 4'hA, ALU_SLTU = 4'hB;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IFETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  state_t            r_state;
  logic [5:0]        r_op, r_fn;
  logic [WAIT_W-1:0] r_wait;
  logic              r_halt, r_mem_err, r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  logic       w_is_r, w_fn_ok, w_op_ok, w_bad, w_imm, w_ovf, w_is_jr, w_sel_act;
  logic [3:0] w_alu;

  always_comb begin
    w_is_r  = (r_op == OP_RTYPE);
    w_is_jr = w_is_r && (r_fn == FN_JR);
    case (r_fn)
      FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: w_fn_ok = 1'b1;
      default:                                        w_fn_ok = 1'b0;
    endcase
    case (r_op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: w_op_ok = 1'b1;
      default:                                                 w_op_ok = 1'b0;
    endcase
    w_bad = !w_op_ok || (w_is_r && !w_fn_ok);
    case (r_op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_imm = 1'b1;
      default:                                                               w_imm = 1'b0;
    endcase
    w_ovf = (w_is_r && (r_fn == FN_ADD || r_fn == FN_SUB)) || (r_op == OP_ADDI);
    case (r_op)
      OP_RTYPE: begin
        case (r_fn)
          FN_SLL:           w_alu = ALU_SLL;
          FN_SRL:           w_alu = ALU_SRL;
          FN_SUB, FN_SUBU:  w_alu = ALU_SUB;
          FN_AND:           w_alu = ALU_AND;
          FN_OR:            w_alu = ALU_OR;
          FN_XOR:           w_alu = ALU_XOR;
          FN_NOR:           w_alu = ALU_NOR;
          FN_SLT:           w_alu = ALU_SLT;
          FN_SLTU:          w_alu = ALU_SLTU;
          default:          w_alu = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: w_alu = ALU_SUB;
      OP_SLTI:        w_alu = ALU_SLT;
      OP_SLTIU:       w_alu = ALU_SLTU;
      OP_ANDI:        w_alu = ALU_AND;
      OP_ORI:         w_alu = ALU_OR;
      OP_XORI:        w_alu = ALU_XOR;
      default:        w_alu = ALU_ADD;
    endcase
  end

  // Datapath selects stay stable for the whole EXEC/MEM/WB span of one instruction.
  assign w_sel_act = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

  always_comb begin
    iren = 1'b0; dren = 1'b0; dwen = 1'b0; PC_EN = 1'b0; PC_src = 2'b00;
    Ext_src = 1'b0; LUI_src = 1'b0; portb_src = 2'b00; RegDst = 2'b00;
    RegWEN = 1'b0; MemtoReg = 2'b00; ALU_op = 4'h0; check_over = 1'b0;
    if (w_sel_act) begin
      Ext_src   = !(r_op == OP_ANDI || r_op == OP_ORI || r_op == OP_XORI);
      LUI_src   = (r_op == OP_LUI);
      portb_src = (w_is_r && (r_fn == FN_SLL || r_fn == FN_SRL)) ? 2'b10 :
                  (w_imm || r_op == OP_LW || r_op == OP_SW)     ? 2'b01 : 2'b00;
      RegDst    = (r_op == OP_JAL) ? 2'b10 : (w_is_r ? 2'b00 : 2'b01);
      ALU_op    = w_alu;
    end
    case (r_state)
      S_IFETCH: iren = 1'b1;
      S_DECODE: begin
        if (!w_bad && r_op == OP_J) begin
          PC_src = 2'b10; PC_EN = 1'b1;
        end else if (w_is_jr) begin
          PC_src = 2'b11; PC_EN = 1'b1;
        end
      end
      S_EXEC: begin
        check_over = w_ovf && (CHECK_OVF != 0);
        if (r_op == OP_BEQ || r_op == OP_BNE) begin
          PC_src = ((r_op == OP_BEQ) ? zero : !zero) ? 2'b01 : 2'b00;
          PC_EN  = 1'b1;
        end
      end
      S_MEM: begin
        dren  = (r_op == OP_LW);
        dwen  = (r_op == OP_SW);
        PC_EN = dhit && (r_op == OP_SW);
      end
      S_WB: begin
        check_over = w_ovf && (CHECK_OVF != 0);
        RegWEN     = 1'b1;
        PC_EN      = 1'b1;
        PC_src     = (r_op == OP_JAL) ? 2'b10 : 2'b00;
        MemtoReg   = (r_op == OP_LW) ? 2'b01 : ((r_op == OP_JAL) ? 2'b10 : 2'b00);
      end
      default: ;
    endcase
    // A reset landing mid-instruction must not retire or write anything.
    if (RST) begin
      PC_EN = 1'b0; RegWEN = 1'b0; dren = 1'b0; dwen = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IFETCH; r_op <= 6'h00; r_fn <= 6'h00; r_wait <= '0;
      r_halt <= 1'b0; r_mem_err <= 1'b0; r_illegal <= 1'b0; r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(PC_EN);
      case (r_state)
        S_IFETCH: if (ihit) begin
          r_op <= opcode; r_fn <= funct; r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (r_op == OP_HALT) begin
            r_state <= S_HALT; r_halt <= 1'b1;
          end else if (w_bad) begin
            r_state <= S_HALT; r_halt <= 1'b1; r_illegal <= 1'b1;
          end else if (r_op == OP_J || w_is_jr) r_state <= S_IFETCH;
          else if (r_op == OP_JAL)              r_state <= S_WB;
          else                                  r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (r_op == OP_BEQ || r_op == OP_BNE)     r_state <= S_IFETCH;
          else if (r_op == OP_LW || r_op == OP_SW)  r_state <= S_MEM;
          else                                      r_state <= S_WB;
        end
        S_MEM: begin
          if (dhit) begin
            r_wait  <= '0;
            r_state <= (r_op == OP_LW) ? S_WB : S_IFETCH;
          end else if (r_wait == c_WAIT_LAST) begin
            r_wait <= '0; r_state <= S_HALT; r_halt <= 1'b1; r_mem_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB:    r_state <= S_IFETCH;
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign halt      = r_halt;
  assign mem_err   = r_mem_err;
  assign illegal   = r_illegal;
  assign instr_cnt = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_multicycle_control_unit: directed bench for the multicycle sequencer   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_multicycle_control_unit;
  logic       CLK = 1'b0, RST = 1'b1, ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic       iren, dren, dwen, PC_EN, Ext_src, LUI_src, RegWEN, check_over, halt, mem_err, illegal;
  logic [1:0] PC_src, portb_src, RegDst, MemtoReg, instr_cnt;
  logic [3:0] ALU_op;
  int pass_cnt = 0, chk_cnt = 0;
  logic [1:0] exp_cnt = 2'd0;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(2), .CHECK_OVF(1)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .opcode(opcode), .funct(funct),
    .zero(zero), .iren(iren), .dren(dren), .dwen(dwen), .PC_EN(PC_EN), .PC_src(PC_src),
    .Ext_src(Ext_src), .LUI_src(LUI_src), .portb_src(portb_src), .RegDst(RegDst),
    .RegWEN(RegWEN), .MemtoReg(MemtoReg), .ALU_op(ALU_op), .check_over(check_over),
    .halt(halt), .mem_err(mem_err), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn; ihit = 1'b1; tick(); ihit = 1'b0; #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; ihit = 1'b0; dhit = 1'b0; tick(); RST = 1'b0; exp_cnt = 2'd0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if ({iren, PC_EN, RegWEN, dren, dwen} !== 5'b10000) $display("FAIL reset_strobes got %b want 10000", {iren, PC_EN, RegWEN, dren, dwen}); else pass_cnt++;
    chk_cnt++; if ({halt, mem_err, illegal, instr_cnt} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {halt, mem_err, illegal, instr_cnt}); else pass_cnt++;
  endtask

  task automatic test_addu();
    tick();
    fetch(6'h00, 6'h21);
    chk_cnt++; if ({PC_EN, RegWEN} !== 2'b00) $display("FAIL addu_decode got %b want 00", {PC_EN, RegWEN}); else pass_cnt++;
    tick();
    chk_cnt++; if ({ALU_op, portb_src, RegDst, PC_EN, RegWEN} !== {4'h2, 2'b00, 2'b00, 2'b00}) $display("FAIL addu_exec got %h want %h", {ALU_op, portb_src, RegDst, PC_EN, RegWEN}, {4'h2, 6'b0}); else pass_cnt++;
    tick();
    chk_cnt++; if ({RegWEN, PC_EN, MemtoReg, PC_src} !== 6'b110000) $display("FAIL addu_wb got %b want 110000", {RegWEN, PC_EN, MemtoReg, PC_src}); else pass_cnt++;
    tick(); exp_cnt = exp_cnt + 2'd1;
    chk_cnt++; if ({iren, RegWEN, instr_cnt} !== {2'b10, exp_cnt}) $display("FAIL addu_retire got %b want %b", {iren, RegWEN, instr_cnt}, {2'b10, exp_cnt}); else pass_cnt++;
  endtask

  task automatic test_lw();
    int n_dren = 0, n_pc = 0;
    fetch(6'h23, 6'h00);
    tick();
    chk_cnt++; if ({ALU_op, portb_src, RegDst, Ext_src} !== {4'h2, 2'b01, 2'b01, 1'b1}) $display("FAIL lw_exec got %h want %h", {ALU_op, portb_src, RegDst, Ext_src}, {4'h2, 2'b01, 2'b01, 1'b1}); else pass_cnt++;
    tick();
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3); #1;
      if (dren) n_dren++;
      if (PC_EN) n_pc++;
      tick();
    end
    dhit = 1'b0; #1;
    chk_cnt++; if ({MemtoReg, RegWEN, PC_EN, dren} !== 5'b01110) $display("FAIL lw_wb got %b want 01110", {MemtoReg, RegWEN, PC_EN, dren}); else pass_cnt++;
    if (PC_EN) n_pc++;
    tick(); exp_cnt = exp_cnt + 2'd1;
    chk_cnt++; if (n_dren !== 4) $display("FAIL lw_dren_cycles got %0d want 4", n_dren); else pass_cnt++;
    chk_cnt++; if ({n_pc[1:0], instr_cnt} !== {2'd1, exp_cnt}) $display("FAIL lw_pc_en got %0d/%0d want 1/%0d", n_pc, instr_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_branch();
    fetch(6'h04, 6'h00);
    tick(); zero = 1'b1; #1;
    chk_cnt++; if ({PC_src, PC_EN, RegWEN, ALU_op} !== {2'b01, 2'b10, 4'h3}) $display("FAIL beq_taken got %h want %h", {PC_src, PC_EN, RegWEN, ALU_op}, {2'b01, 2'b10, 4'h3}); else pass_cnt++;
    tick(); exp_cnt = exp_cnt + 2'd1;
    fetch(6'h05, 6'h00);
    tick(); #1;
    chk_cnt++; if ({PC_src, PC_EN, RegWEN} !== 4'b0010) $display("FAIL bne_not_taken got %b want 0010", {PC_src, PC_EN, RegWEN}); else pass_cnt++;
    tick(); exp_cnt = exp_cnt + 2'd1; zero = 1'b0;
    chk_cnt++; if ({iren, RegWEN, instr_cnt} !== {2'b10, exp_cnt}) $display("FAIL branch_retire got %b want %b", {iren, RegWEN, instr_cnt}, {2'b10, exp_cnt}); else pass_cnt++;
  endtask

  task automatic test_jumps();
    fetch(6'h03, 6'h00);
    tick();
    chk_cnt++; if ({RegDst, MemtoReg, PC_src, RegWEN, PC_EN} !== 8'b10101011) $display("FAIL jal_wb got %b want 10101011", {RegDst, MemtoReg, PC_src, RegWEN, PC_EN}); else pass_cnt++;
    tick(); exp_cnt = exp_cnt + 2'd1;
    chk_cnt++; if (instr_cnt !== 2'd1) $display("FAIL cnt_wrap got %0d want 1", instr_cnt); else pass_cnt++;
    fetch(6'h02, 6'h00);
    chk_cnt++; if ({PC_src, PC_EN, RegWEN} !== 4'b1010) $display("FAIL j_decode got %b want 1010", {PC_src, PC_EN, RegWEN}); else pass_cnt++;
    tick(); exp_cnt = exp_cnt + 2'd1;
    fetch(6'h00, 6'h08);
    chk_cnt++; if ({PC_src, PC_EN, RegWEN} !== 4'b1110) $display("FAIL jr_decode got %b want 1110", {PC_src, PC_EN, RegWEN}); else pass_cnt++;
    tick(); exp_cnt = exp_cnt + 2'd1;
    chk_cnt++; if ({iren, instr_cnt} !== {1'b1, exp_cnt}) $display("FAIL jump_retire got %b want %b", {iren, instr_cnt}, {1'b1, exp_cnt}); else pass_cnt++;
  endtask

  task automatic test_imm_ops();
    fetch(6'h08, 6'h00);
    tick();
    chk_cnt++; if ({check_over, portb_src, RegDst, Ext_src, ALU_op} !== {1'b1, 2'b01, 2'b01, 1'b1, 4'h2}) $display("FAIL addi_exec got %h want %h", {check_over, portb_src, RegDst, Ext_src, ALU_op}, {1'b1, 2'b01, 2'b01, 1'b1, 4'h2}); else pass_cnt++;
    tick();
    chk_cnt++; if ({check_over, RegWEN} !== 2'b11) $display("FAIL addi_wb got %b want 11", {check_over, RegWEN}); else pass_cnt++;
    tick(); exp_cnt = exp_cnt + 2'd1;
    fetch(6'h0D, 6'h00);
    tick();
    chk_cnt++; if ({check_over, Ext_src, LUI_src, ALU_op} !== {3'b000, 4'h5}) $display("FAIL ori_exec got %h want %h", {check_over, Ext_src, LUI_src, ALU_op}, {3'b000, 4'h5}); else pass_cnt++;
    tick(); tick(); exp_cnt = exp_cnt + 2'd1;
    fetch(6'h00, 6'h00);
    tick();
    chk_cnt++; if ({portb_src, RegDst, ALU_op, check_over} !== {2'b10, 2'b00, 4'h0, 1'b0}) $display("FAIL sll_exec got %h want %h", {portb_src, RegDst, ALU_op, check_over}, {2'b10, 2'b00, 4'h0, 1'b0}); else pass_cnt++;
    tick(); tick(); exp_cnt = exp_cnt + 2'd1;
    chk_cnt++; if (instr_cnt !== exp_cnt) $display("FAIL imm_retire got %0d want %0d", instr_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_sw_timeout();
    int n_dwen = 0, n_bad = 0;
    fetch(6'h2B, 6'h00);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      dhit = 1'b0; #1;
      if (dwen) n_dwen++;
      tick();
    end
    chk_cnt++; if (n_dwen !== 4) $display("FAIL sw_dwen_cycles got %0d want 4", n_dwen); else pass_cnt++;
    chk_cnt++; if ({halt, mem_err, illegal} !== 3'b110) $display("FAIL sw_timeout_flags got %b want 110", {halt, mem_err, illegal}); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      ihit = 1'b1; dhit = 1'b1; #1;
      if (iren | dren | dwen | PC_EN | RegWEN | check_over | !halt | !mem_err) n_bad++;
      tick();
    end
    ihit = 1'b0; dhit = 1'b0;
    chk_cnt++; if (n_bad !== 0) $display("FAIL halt_quiet got %0d active cycles want 0", n_bad); else pass_cnt++;
    chk_cnt++; if (instr_cnt !== exp_cnt) $display("FAIL halt_cnt_hold got %0d want %0d", instr_cnt, exp_cnt); else pass_cnt++;
    do_reset();
    chk_cnt++; if ({halt, mem_err, illegal, iren} !== 4'b0001) $display("FAIL timeout_reset got %b want 0001", {halt, mem_err, illegal, iren}); else pass_cnt++;
  endtask

  task automatic test_halt_illegal();
    fetch(6'h3F, 6'h00);
    tick();
    chk_cnt++; if ({halt, illegal, mem_err, iren} !== 4'b1000) $display("FAIL halt_op got %b want 1000", {halt, illegal, mem_err, iren}); else pass_cnt++;
    do_reset();
    fetch(6'h3E, 6'h00);
    tick();
    chk_cnt++; if ({halt, illegal, PC_EN} !== 3'b110) $display("FAIL illegal_op got %b want 110", {halt, illegal, PC_EN}); else pass_cnt++;
    do_reset();
    chk_cnt++; if ({halt, illegal, mem_err, iren, instr_cnt} !== 6'b000100) $display("FAIL illegal_reset got %b want 000100", {halt, illegal, mem_err, iren, instr_cnt}); else pass_cnt++;
    fetch(6'h00, 6'h3F);
    tick();
    chk_cnt++; if ({halt, illegal} !== 2'b11) $display("FAIL illegal_funct got %b want 11", {halt, illegal}); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_mid_reset();
    fetch(6'h00, 6'h21);
    tick(); tick();
    RST = 1'b1; #1;
    chk_cnt++; if ({PC_EN, RegWEN} !== 2'b00) $display("FAIL mid_reset_strobes got %b want 00", {PC_EN, RegWEN}); else pass_cnt++;
    tick(); RST = 1'b0; exp_cnt = 2'd0; #1;
    chk_cnt++; if ({iren, RegWEN, instr_cnt} !== 4'b1000) $display("FAIL mid_reset_state got %b want 1000", {iren, RegWEN, instr_cnt}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw();
    test_branch();
    test_jumps();
    test_imm_ops();
    test_sw_timeout();
    test_halt_illegal();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle control decoder. Sequences each MIPS instruction through fetch, decode, execute, memory and writeback states.
- Holds a latched copy of opcode/funct and waits on the ihit/dhit memory handshakes.
- Applies a parametrised memory-wait timeout and keeps a retired-instruction counter.
- Sits between the cache/memory interface and the datapath, replacing the combinational control unit.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive MEM-state wait cycles without dhit before a fatal halt.
- CNT_W, 32: width of the retired-instruction counter.
- CHECK_OVF, 1: when 1, check_over is asserted for add/addi/sub; when 0, check_over is tied 0.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction memory returns valid instr this cycle.
- dhit  in  1  data memory access completes this cycle.
- opcode  in  6  opcode_t from the instruction bus; sampled only on ihit in IFETCH.
- funct  in  6  funct_t from the instruction bus; sampled only on ihit in IFETCH.
- zero  in  1  ALU zero flag; valid in EXEC.
- iren  out  1  instruction read request.
- dren  out  1  data read request.
- dwen  out  1  data write request.
- PC_EN  out  1  PC update strobe.
- PC_src  out  2  00 +4, 01 branch, 10 jump, 11 register.
- Ext_src  out  1  1 sign-extend, 0 zero-extend.
- LUI_src  out  1  1 for lui.
- portb_src  out  2  00 rt, 01 imm, 10 shamt.
- RegDst  out  2  00 rd, 01 rt, 10 r31.
- RegWEN  out  1  register file write strobe.
- MemtoReg  out  2  00 alu, 01 mem, 10 pc+4.
- ALU_op  out  4  aluop_t.
- check_over  out  1  overflow check enable.
- halt  out  1  sticky halt.
- mem_err  out  1  sticky timeout flag.
- illegal  out  1  sticky unknown-opcode flag.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset:
  - State goes to IFETCH.
  - All strobes (iren excepted), halt, mem_err, illegal and instr_cnt are 0.
  - Latched opcode/funct are 0; wait counter is 0.
  - iren is 1 in the first cycle after reset.
  - RST mid-instruction aborts with no PC_EN or RegWEN.
- States: IFETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- IFETCH:
  - iren=1 until ihit.
  - On ihit: latch opcode/funct, go to DECODE.
  - Without ihit: stay; no timeout here.
- DECODE (1 cycle):
  - HALT opcode (0x3F): go to HALT, halt=1.
  - Unrecognised opcode, or funct in R-type: go to HALT, illegal=1, halt=1.
  - J: PC_src=10, PC_EN=1, go to IFETCH.
  - JAL: go to WB.
  - JR (R-type, funct 0x08): PC_src=11, PC_EN=1, go to IFETCH.
  - Otherwise: go to EXEC.
- EXEC (1 cycle):
  - ALU_op: from funct for R-type; ADD for lw/sw/addi/addiu; SUB for beq/bne; AND/OR/XOR/SLT/SLTU for the matching immediates.
  - BEQ/BNE: taken = zero for BEQ, ~zero for BNE. PC_src=01 if taken, else 00. PC_EN=1, go to IFETCH.
  - LW/SW: go to MEM.
  - All others: go to WB.
- Static datapath selects (held through EXEC/MEM/WB of the latched instruction; 0 elsewhere):
  - Ext_src=1 except andi/ori/xori.
  - LUI_src=1 for lui.
  - portb_src=10 for sll/srl; 01 for immediates/lw/sw; 00 otherwise.
  - RegDst=00 R-type, 01 I-type, 10 jal.
- MEM:
  - dren=1 for lw, dwen=1 for sw, held until dhit.
  - Wait counter increments each cycle without dhit.
  - dhit on lw: go to WB.
  - dhit on sw: PC_EN=1, go to IFETCH.
  - Counter reaching MEM_TIMEOUT without dhit: go to HALT with mem_err=1. dren/dwen drop that cycle.
  - dhit in the same cycle the counter reaches MEM_TIMEOUT: dhit wins.
  - Counter clears on leaving MEM.
- WB (1 cycle):
  - RegWEN=1, PC_EN=1.
  - PC_src=10 for jal, else 00.
  - MemtoReg=01 for lw, 10 for jal, else 00.
  - Go to IFETCH.
- Every PC_EN pulse increments instr_cnt by 1, wrapping at 2^CNT_W modulo.
- Each instruction produces exactly one PC_EN pulse and at most one RegWEN pulse.
- check_over=CHECK_OVF for add, sub and addi during EXEC and WB only.
- HALT: absorbing until RST.
  - All request and strobe outputs are 0.
  - halt, mem_err and illegal hold their values.
  - ihit/dhit are ignored.

Test Plan:
- addu (opcode 0, funct 0x21), ihit on cycle 2 after reset -> DECODE, EXEC, WB; RegWEN=1 and PC_EN=1 in the same single cycle; instr_cnt=1.
- lw, dhit delayed 3 cycles -> dren high 4 cycles; then WB with MemtoReg=01, RegWEN=1; PC_EN exactly once.
- beq with zero=1, then bne with zero=1 -> PC_src=01 then 00; each with PC_EN=1 in EXEC; RegWEN never asserts.
- sw with dhit never asserted, MEM_TIMEOUT=4 -> dwen high 4 cycles; then HALT with mem_err=1, halt=1; outputs stay 0 through 10 further cycles.
- Opcode 0x3F -> HALT after DECODE, halt=1, illegal=0. Opcode 0x3E -> halt=1, illegal=1. RST high one cycle -> all flags 0, iren=1.
- jal -> WB with RegDst=10, MemtoReg=10, PC_src=10, RegWEN=1. With CNT_W=2, 5 instructions give instr_cnt=1 (wrap).
